result_checker: RTL

- Synthesizable self-check monitor. It snoops the CPU data-memory write port (d_mem_addr/d_mem_wdata/d_mem_wen) downstream of cpu_top.
- It captures word results written into a fixed result window, with byte-lane merging.
- On a stop-address write or a cycle timeout it compares each captured slot against expected constants, one slot per cycle, and reports pass/fail per slot.
- It replaces end-of-sim checking in integration benches and allows on-FPGA self-test.

---
 rtl/result_checker_pkg.sv | 19 +
 rtl/result_checker_slot_reg.sv | 39 +++
 rtl/result_checker.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/result_checker_pkg.sv
// result_checker_pkg
// Shared definitions for the result checker: FSM state encoding, default
// window/stop addresses, timeout length and byte-lane geometry.
package result_checker_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR      = 32'h0000_0100;
  localparam logic [31:0] DEF_STOP_ADDR      = 32'h0000_01FC;
  localparam int          DEF_TIMEOUT_CYCLES = 300;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;

endpackage

// File: rtl/result_checker_slot_reg.sv
// result_slot_reg
// One 32-bit result slot: byte-lane merging register plus a sticky
// "written" flag. Lanes not enabled keep their previous contents.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   i_wen       per-lane write enables (already qualified by slot select)
//   i_wdata     write data
//   o_data      stored value
//   o_written   set once any lane has been written since reset
module result_slot_reg
  import result_checker_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  i_wen,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_data,
  output logic        o_written
);

  logic [31:0] r_data;
  logic        r_written;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_written <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (i_wen[k]) r_data[LANE_W*k +: LANE_W] <= i_wdata[LANE_W*k +: LANE_W];
      end
      if (|i_wen) r_written <= 1'b1;
    end
  end

  assign o_data    = r_data;
  assign o_written = r_written;

endmodule

// File: rtl/result_checker.sv
// result_checker
// Snoops the CPU data-memory write port, captures word results written into
// a fixed window, and on a stop-address write or a cycle timeout compares
// each slot against its expected constant, one slot per cycle.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   d_mem_addr     CPU data byte address
//   d_mem_wdata    CPU write data
//   d_mem_wen      byte-lane write enables
//   rd_idx         slot readback index
//   rd_data        captured value of slot rd_idx (0 when out of range)
//   rd_written     slot rd_idx written at least once (0 when out of range)
//   done           check complete, held until reset
//   pass           all slots matched (meaningful while done)
//   fail_mask      per-slot mismatch / never-written flags
//   timed_out      run ended by timeout rather than a stop write
//   cycle_count    RUN cycles elapsed, saturating
//   stray_writes   misaligned writes into the window, saturating
module result_checker
  import result_checker_pkg::*;
#(
  parameter logic [31:0]               BASE_ADDR      = DEF_BASE_ADDR,
  parameter int                        NUM_RESULTS    = 6,
  parameter logic [NUM_RESULTS*32-1:0] EXPECTED       = {32'd300, 32'd7, 32'd0, 32'd2, 32'd30, 32'd3},
  parameter logic [31:0]               STOP_ADDR      = DEF_STOP_ADDR,
  parameter int                        TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int                        CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            d_mem_addr,
  input  logic [31:0]            d_mem_wdata,
  input  logic [3:0]             d_mem_wen,
  input  logic [4:0]             rd_idx,
  output logic [31:0]            rd_data,
  output logic                   rd_written,
  output logic                   done,
  output logic                   pass,
  output logic [NUM_RESULTS-1:0] fail_mask,
  output logic                   timed_out,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [CNT_W-1:0]       stray_writes
);

  state_t                 r_state, w_state_next;
  logic [4:0]             r_idx;
  logic [NUM_RESULTS-1:0] r_fail_mask;
  logic                   r_done, r_pass, r_timed_out;
  logic [CNT_W-1:0]       r_cycle_count, r_stray_writes;

  logic [31:0]            w_word_addr;
  logic [NUM_RESULTS-1:0] w_hit;
  logic                   w_event, w_aligned, w_in_win, w_is_run;
  logic                   w_capture, w_stray, w_stop, w_timeout;
  logic [3:0]             w_slot_wen     [NUM_RESULTS];
  logic [31:0]            w_slot_data    [NUM_RESULTS];
  logic [NUM_RESULTS-1:0] w_slot_written;
  logic [NUM_RESULTS-1:0] w_fail_next;
  logic                   w_last;

  // Address decode: a word address matches at most one slot. Misaligned
  // byte addresses still resolve to their containing word so they can be
  // counted as strays.
  assign w_word_addr = {d_mem_addr[31:2], 2'b00};
  assign w_event     = |d_mem_wen;
  assign w_aligned   = (d_mem_addr[1:0] == 2'b00);
  assign w_is_run    = (r_state == ST_RUN);
  assign w_in_win    = |w_hit;

  assign w_capture = w_is_run && w_event && w_in_win && w_aligned;
  assign w_stray   = w_is_run && w_event && w_in_win && !w_aligned;
  assign w_stop    = w_is_run && w_event && (d_mem_addr == STOP_ADDR);
  // Stop has priority when both end conditions land on the same edge.
  assign w_timeout = w_is_run && !w_stop &&
                     (r_cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

  for (genvar g = 0; g < NUM_RESULTS; g++) begin : g_slot
    assign w_hit[g]      = (w_word_addr == BASE_ADDR + 32'(4 * g));
    assign w_slot_wen[g] = (w_capture && w_hit[g]) ? d_mem_wen : 4'b0000;

    result_slot_reg u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wen     (w_slot_wen[g]),
      .i_wdata   (d_mem_wdata),
      .o_data    (w_slot_data[g]),
      .o_written (w_slot_written[g])
    );
  end

  // Sequential compare: fold the verdict for slot r_idx into the mask.
  always_comb begin
    w_fail_next = r_fail_mask;
    for (int i = 0; i < NUM_RESULTS; i++) begin
      if (r_idx == 5'(i)) begin
        w_fail_next[i] = ~(w_slot_written[i] &&
                           (w_slot_data[i] == EXPECTED[32*i +: 32]));
      end
    end
  end

  assign w_last = (r_idx == 5'(NUM_RESULTS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (w_stop || w_timeout) w_state_next = ST_CHECK;
      ST_CHECK: if (w_last)              w_state_next = ST_DONE;
      ST_DONE:                           w_state_next = ST_DONE;
      default:                           w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx          <= '0;
      r_fail_mask    <= '0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_timed_out    <= 1'b0;
      r_cycle_count  <= '0;
      r_stray_writes <= '0;
    end else begin
      if (r_state == ST_RUN) begin
        if (r_cycle_count != '1)                  r_cycle_count  <= r_cycle_count + 1'b1;
        if (w_stray && (r_stray_writes != '1))    r_stray_writes <= r_stray_writes + 1'b1;
        if (w_timeout)                            r_timed_out    <= 1'b1;
      end else if (r_state == ST_CHECK) begin
        r_fail_mask <= w_fail_next;
        r_idx       <= r_idx + 5'd1;
        if (w_last) begin
          r_pass <= (w_fail_next == '0);
          r_done <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_data    = '0;
    rd_written = 1'b0;
    for (int i = 0; i < NUM_RESULTS; i++) begin
      if (rd_idx == 5'(i)) begin
        rd_data    = w_slot_data[i];
        rd_written = w_slot_written[i];
      end
    end
  end

  assign done         = r_done;
  assign pass         = r_pass;
  assign fail_mask    = r_fail_mask;
  assign timed_out    = r_timed_out;
  assign cycle_count  = r_cycle_count;
  assign stray_writes = r_stray_writes;

endmodule
